// File: rtl/alu_op_sequencer_pkg.sv
// ============================================================================
// Module      : alu_op_sequencer_pkg
// Description : Shared opcode constants, FSM state encoding and command
//               record for the ALU operation sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_op_sequencer_pkg;

    // ALU opcodes
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b011;
    localparam logic [2:0] OP_SHR = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    // Command entry width: {op, a, b}
    localparam int CMD_W = 19;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    // Only add and subtract produce a meaningful carry/borrow
    function automatic logic op_has_cb(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_op_sequencer_cmd_fifo.sv
// ============================================================================
// Module      : alu_cmd_fifo
// Description : Power-of-two deep command FIFO with occupancy count. Push is
//               refused when full even if a pop happens in the same cycle;
//               pop is refused when empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_fifo
    import alu_op_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [CMD_W-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [CMD_W-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic do_push;
    logic do_pop;

    assign full_o  = !(count_q < FULL_CNT);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && (count_q != '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage array: written on accepted push, intentionally not reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks net push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// Module      : alu_op_sequencer
// Description : Queues ALU commands, issues them one at a time to an external
//               combinational ALU, captures each result and holds it until the
//               consumer accepts it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_a,
    input  logic [7:0]               in_b,
    input  logic [2:0]               in_op,
    output logic [7:0]               alu_a,
    output logic [7:0]               alu_b,
    output logic [2:0]               alu_op,
    input  logic [15:0]              alu_out,
    input  logic                     alu_cb,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [15:0]              res_data,
    output logic                     res_cb,
    output logic                     res_zero,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);

    state_e           state_q;
    cmd_t             opnd_q;
    logic             res_valid_q;
    logic [15:0]      res_data_q;
    logic             res_cb_q;
    logic             res_zero_q;

    logic [CMD_W-1:0] fifo_rdata;
    logic             fifo_full;
    logic             fifo_pop;
    logic             queue_nz;

    assign queue_nz = (count != '0);

    // Pop exactly when the FSM moves a queued command into the operand register
    assign fifo_pop = queue_nz &&
                      ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && res_ready));

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid),
        .wdata_i ({in_op, in_a, in_b}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (count),
        .full_o  (fifo_full)
    );

    assign in_ready  = !fifo_full;
    assign busy      = (state_q != ST_IDLE);
    assign alu_a     = opnd_q.a;
    assign alu_b     = opnd_q.b;
    assign alu_op    = opnd_q.op;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_cb    = res_cb_q;
    assign res_zero  = res_zero_q;

    // Sequencer FSM: load operand, capture ALU result for one cycle, hold it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            opnd_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_cb_q    <= 1'b0;
            res_zero_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (queue_nz) begin
                        opnd_q  <= cmd_t'(fifo_rdata);
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    res_data_q  <= alu_out;
                    res_zero_q  <= (alu_out == 16'h0000);
                    res_cb_q    <= op_has_cb(opnd_q.op) & alu_cb;
                    res_valid_q <= 1'b1;
                    state_q     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        if (queue_nz) begin
                            opnd_q  <= cmd_t'(fifo_rdata);
                            state_q <= ST_EXEC;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
